// File: rtl/tuser_tuple_fifo_pkg.sv
// Shared definitions for the TUSER tuple capture path.
package tuple_pkg;

  localparam int unsigned DEF_TUSER_W = 128;

  localparam int unsigned CAP_FIRST = 0;
  localparam int unsigned CAP_LAST  = 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tuser_tuple_fifo_if.sv
// AXIS sideband input and SDNet tuple output bundle.
interface tuser_tuple_fifo_if
  import tuple_pkg::*;
#(
  parameter int unsigned TUSER_W = DEF_TUSER_W,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned CNT_W  = addr_w(DEPTH) + 1
);

  logic               tin_avalid;
  logic               tin_aready;
  logic [TUSER_W-1:0] tin_atuser;
  logic               tin_atlast;
  logic               tin_valid;
  logic               tin_ready;
  logic [TUSER_W-1:0] tin_data;
  logic [CNT_W-1:0]   tin_count;

  modport master (
    output tin_avalid, tin_atuser, tin_atlast, tin_ready,
    input  tin_aready, tin_valid, tin_data, tin_count
  );

  modport slave (
    input  tin_avalid, tin_atuser, tin_atlast, tin_ready,
    output tin_aready, tin_valid, tin_data, tin_count
  );

endinterface

// File: rtl/tuser_tuple_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-flag pointers; storage is not reset.
module tuple_sync_fifo
  import tuple_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_TUSER_W,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tuser_tuple_fifo.sv
// Captures TUSER once per packet and queues it as an SDNet tuple.
module tuser_tuple_fifo
  import tuple_pkg::*;
#(
  parameter int unsigned TUSER_W      = DEF_TUSER_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CAPTURE_LAST = CAP_FIRST,
  localparam int unsigned CNT_W       = addr_w(DEPTH) + 1
) (
  input  logic              tin_aclk,
  input  logic              tin_arst_n,
  tuser_tuple_fifo_if.slave tin
);

  logic               sop;
  logic               cap;
  logic               acc;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [TUSER_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;

  assign cap            = (CAPTURE_LAST == CAP_LAST) ? tin.tin_atlast : sop;
  // Stall only the capture beat when full so packets and tuples stay paired.
  assign tin.tin_aready = ~(cap & full);
  assign acc            = tin.tin_avalid & tin.tin_aready;
  assign push           = acc & cap;
  assign pop            = tin.tin_valid & tin.tin_ready;

  assign tin.tin_valid  = ~empty;
  assign tin.tin_data   = empty ? '0 : rd_data;
  assign tin.tin_count  = count;

  always_ff @(posedge tin_aclk or negedge tin_arst_n) begin
    if (!tin_arst_n) begin
      sop <= 1'b1;
    end else if (acc) begin
      sop <= tin.tin_atlast;
    end
  end

  tuple_sync_fifo #(
    .WIDTH (TUSER_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (tin_aclk),
    .rst_n   (tin_arst_n),
    .push    (push),
    .wr_data (tin.tin_atuser),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_tuser_tuple_fifo.sv
// Two lanes: capture-first and capture-last, each with a queue-based reference.
module tb_tuser_tuple_fifo;
  import tuple_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = addr_w(D) + 1;
  localparam int          NRAND = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit stop_rand = 1'b0;

  logic [1:0]         avalid;
  logic [1:0]         atlast;
  logic [1:0]         ready;
  logic [1:0][W-1:0]  atuser;
  logic [1:0]         aready_o;
  logic [1:0]         valid_o;
  logic [1:0][W-1:0]  data_o;
  logic [1:0][CW-1:0] count_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned MODE = g;

    tuser_tuple_fifo_if #(.TUSER_W(W), .DEPTH(D)) bus ();

    tuser_tuple_fifo #(
      .TUSER_W      (W),
      .DEPTH        (D),
      .CAPTURE_LAST (MODE)
    ) dut (
      .tin_aclk   (clk),
      .tin_arst_n (rst_n),
      .tin        (bus.slave)
    );

    assign bus.tin_avalid = avalid[g];
    assign bus.tin_atuser = atuser[g];
    assign bus.tin_atlast = atlast[g];
    assign bus.tin_ready  = ready[g];
    assign aready_o[g]    = bus.tin_aready;
    assign valid_o[g]     = bus.tin_valid;
    assign data_o[g]      = bus.tin_data;
    assign count_o[g]     = bus.tin_count;

    // Reference: a queue of captured tuples; occupancy is its size.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] plog[$];
    int           maxcnt = 0;

    initial begin
      bit           m_sop;
      bit           cap;
      bit           exp_ready;
      bit           hold;
      logic [W-1:0] hold_data;
      m_sop = 1'b1;
      hold  = 1'b0;
      hold_data = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_valid", 64'(valid_o[g]), 64'(0));
          chk("rst_data", 64'(data_o[g]), 64'(0));
          chk("rst_count", 64'(count_o[g]), 64'(0));
          chk("rst_aready", 64'(aready_o[g]), 64'(1));
          exp_q.delete();
          m_sop = 1'b1;
          hold  = 1'b0;
        end else begin
          cap       = (MODE == 1) ? atlast[g] : m_sop;
          exp_ready = !(cap && exp_q.size() == D);
          chk("count", 64'(count_o[g]), 64'(exp_q.size()));
          chk("valid", 64'(valid_o[g]), 64'(exp_q.size() != 0));
          chk("data", 64'(data_o[g]), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'(0));
          chk("aready", 64'(aready_o[g]), 64'(exp_ready));
          if (hold) chk("hold_data", 64'(data_o[g]), 64'(hold_data));
          if (int'(count_o[g]) > maxcnt) maxcnt = int'(count_o[g]);
          hold      = valid_o[g] && !ready[g];
          hold_data = data_o[g];
          if (valid_o[g] && ready[g]) begin
            plog.push_back(data_o[g]);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
          if (avalid[g] && exp_ready) begin
            if (cap) exp_q.push_back(atuser[g]);
            m_sop = atlast[g];
          end
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int l, input logic [W-1:0] u, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    avalid[l] = 1'b1;
    atuser[l] = u;
    atlast[l] = last;
    while (!acc) begin
      @(negedge clk);
      acc = aready_o[l];
      @(posedge clk);
      #1;
      n++;
      if (!acc && n >= 300) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: lane %0d beat %0h never accepted", l, u);
        break;
      end
    end
    avalid[l] = 1'b0;
    atlast[l] = 1'b0;
    atuser[l] = $urandom;
  endtask

  task automatic send_pkt(input int l, input int len, input logic [W-1:0] first, input logic [W-1:0] lastu);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) send_beat(l, lastu, 1'b1);
      else if (i == 0)  send_beat(l, first, 1'b0);
      else              send_beat(l, $urandom, 1'b0);
    end
  endtask

  task automatic rand_lane(input int l);
    int len;
    logic [W-1:0] u;
    for (int p = 0; p < NRAND; p++) begin
      if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(1, 3)));
      len = int'($urandom_range(1, 5));
      for (int b = 0; b < len; b++) begin
        u = $urandom;
        send_beat(l, u, b == len - 1);
        if ($urandom_range(0, 7) == 0) cyc(1);
      end
    end
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    avalid = '0;
    atlast = '0;
    ready  = '0;
    atuser = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk("init_valid", 64'(valid_o[l]), 64'(0));
      chk("init_count", 64'(count_o[l]), 64'(0));
      chk("init_aready", 64'(aready_o[l]), 64'(1));
    end
    rst_n = 1'b1;
    cyc(2);

    // Three capture-first packets with a ready consumer.
    ready = 2'b11;
    lane[0].maxcnt = 0;
    send_pkt(0, 4, W'('h11), $urandom);
    send_pkt(0, 4, W'('h22), $urandom);
    send_pkt(0, 4, W'('h33), $urandom);
    cyc(3);
    chk("t1_ntuples", 64'(lane[0].plog.size()), 64'(3));
    if (lane[0].plog.size() == 3) begin
      chk("t1_tuple0", 64'(lane[0].plog[0]), 64'('h11));
      chk("t1_tuple1", 64'(lane[0].plog[1]), 64'('h22));
      chk("t1_tuple2", 64'(lane[0].plog[2]), 64'('h33));
    end
    chk("t1_peak_count", 64'(lane[0].maxcnt), 64'(1));

    // Capture-last lane: multi-beat then single-beat packet.
    send_pkt(1, 3, W'('hA), W'('hB));
    send_pkt(1, 1, W'('hC), W'('hC));
    cyc(3);
    chk("t2_ntuples", 64'(lane[1].plog.size()), 64'(2));
    if (lane[1].plog.size() == 2) begin
      chk("t2_tuple0", 64'(lane[1].plog[0]), 64'('hB));
      chk("t2_tuple1", 64'(lane[1].plog[1]), 64'('hC));
    end

    // Fill with the consumer stalled, then release on a pending capture beat.
    lane[0].plog.delete();
    ready[0] = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(0, 4, W'('h41 + p), $urandom);
    chk("t3_full_count", 64'(count_o[0]), 64'(4));
    fork
      send_pkt(0, 4, W'('h45), $urandom);
    join_none
    cyc(3);
    chk("t3_stalled_aready", 64'(aready_o[0]), 64'(0));
    chk("t3_stalled_count", 64'(count_o[0]), 64'(4));
    ready[0] = 1'b1;
    wait fork;
    send_pkt(0, 4, W'('h46), $urandom);
    cyc(10);
    chk("t3_ntuples", 64'(lane[0].plog.size()), 64'(6));
    if (lane[0].plog.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", 64'(lane[0].plog[i]), 64'('h41 + i));
    end

    // Asynchronous reset mid-packet with two tuples queued.
    lane[0].plog.delete();
    ready[0] = 1'b0;
    send_pkt(0, 2, W'('h51), $urandom);
    send_beat(0, W'('h52), 1'b0);
    send_beat(0, W'('h99), 1'b0);
    chk("t4_queued", 64'(count_o[0]), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_valid", 64'(valid_o[0]), 64'(0));
    chk("t4_async_data", 64'(data_o[0]), 64'(0));
    chk("t4_async_count", 64'(count_o[0]), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    ready[0] = 1'b1;
    send_beat(0, W'('h77), 1'b0);
    send_beat(0, $urandom, 1'b0);
    send_beat(0, $urandom, 1'b1);
    cyc(3);
    chk("t4_ntuples", 64'(lane[0].plog.size()), 64'(1));
    if (lane[0].plog.size() == 1) chk("t4_tuple", 64'(lane[0].plog[0]), 64'('h77));

    // Random traffic and consumer stalls on both lanes.
    lane[0].plog.delete();
    lane[1].plog.delete();
    fork
      begin
        fork
          rand_lane(0);
          rand_lane(1);
        join
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          ready[0] = $urandom_range(0, 3) != 0;
          ready[1] = $urandom_range(0, 2) != 0;
        end
      end
    join
    ready = 2'b11;
    cyc(20);
    for (int l = 0; l < 2; l++) chk("rand_drained", 64'(count_o[l]), 64'(0));
    chk("rand_ntuples0", 64'(lane[0].plog.size()), 64'(NRAND));
    chk("rand_ntuples1", 64'(lane[1].plog.size()), 64'(NRAND));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tuser_tuple_fifo.md
# tuser_tuple_fifo

- Parametrised successor to the single-register TUSER capture FSM.
- Samples the AXI4-Stream TUSER sideband once per packet, on the first beat or the last beat (selectable), and queues it in a DEPTH-entry tuple FIFO.
- Presents queued tuples to the SDNet tuple input with a valid/ready handshake.
- Applies backpressure to the packet stream only on capture beats while the FIFO is full. This keeps packet and tuple streams aligned one-to-one.

## Interface

Parameters:
- TUSER_W, 128: TUSER and tuple width in bits.
- DEPTH, 4: tuple FIFO entries; must be a power of two, ≥2.
- CAPTURE_LAST, 0: 0 = capture TUSER on the first beat of a packet; 1 = capture on the tlast beat.

Ports:
- tin_aclk  in  1  single clock; all logic on rising edge.
- tin_arst_n  in  1  reset, asynchronous assert, active-low.
- tin_avalid  in  1  AXIS beat valid.
- tin_aready  out  1  AXIS beat ready.
- tin_atuser  in  TUSER_W  AXIS sideband.
- tin_atlast  in  1  AXIS last beat of packet.
- tin_valid  out  1  tuple valid.
- tin_ready  in  1  tuple consumer ready.
- tin_data  out  TUSER_W  tuple data.
- tin_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- Beat accepted: acc = tin_avalid & tin_aready.
- sop register, reset 1: cleared on acc & ~tin_atlast; set on acc & tin_atlast.
- Capture beat:
  - cap = sop when CAPTURE_LAST=0.
  - cap = tin_atlast when CAPTURE_LAST=1.
- Single-beat packets (sop and tlast on the same beat) push exactly one tuple in either mode.
- tin_aready = ~(cap & full).
  - Non-capture beats always flow.
  - Never depends on tin_ready; there is no combinational path from tin_ready to tin_aready.
- push = acc & cap: writes tin_atuser at wr_ptr.
- pop = tin_valid & tin_ready.
- FIFO pointers:
  - Pointers are $clog2(DEPTH)+1 bits; the address is the low bits and the MSB is the wrap flag.
  - empty: pointers equal.
  - full: addresses equal and MSBs differ.
- tin_valid = ~empty.
- tin_data = mem[rd_addr] when non-empty, else all-zero (show-ahead).
- tin_count = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- Simultaneous push and pop:
  - When non-empty and not full: occupancy unchanged, both pointers advance.
  - When full: push is impossible because tin_aready is low, even if a pop occurs that cycle. The freed slot is usable next cycle.
  - When empty: pop is impossible because tin_valid is low. The pushed tuple appears next cycle.
- tin_data must hold stable while tin_valid & ~tin_ready (AXIS rule on the tuple side).
- Consumer misuse: tin_atuser changes on non-capture beats are ignored.

## Timing

- Reset (tin_arst_n low, asynchronous):
  - Outputs: tin_valid=0, tin_data=0, tin_count=0, tin_aready=1 (DEPTH≥1 means not full).
  - Internal: sop=1, both pointers 0.
  - Memory contents are not reset.
- Reset deasserted mid-packet: the next accepted beat is treated as start-of-packet; remaining beats of the interrupted packet are indistinguishable and are not compensated.
- Latency: a tuple captured at edge N is on tin_data with tin_valid=1 after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle.
- DEPTH entries can buffer DEPTH packets ahead of the tuple consumer.
- Full-to-not-full: tin_aready rises in the cycle after the pop edge.

## Structure

- Shared package tuple_pkg holds:
  - TUSER_W default
  - ADDR_W function (clog2)
  - capture-mode localparams CAP_FIRST=0 and CAP_LAST=1
- One natural sub-module: tuple_sync_fifo, a parametrised show-ahead synchronous FIFO (width, depth; push/pop/full/empty/count).
- The top level keeps only the sop tracker, cap/ready gating and zero-masking of tin_data.
- Target size: ~150–250 RTL lines total.

## Test plan

- Reset then three 4-beat packets with TUSER 0x11, 0x22, 0x33 on the first beat; tin_ready=1, CAPTURE_LAST=0 → tuples 0x11, 0x22, 0x33 each valid for one cycle, one cycle after the respective SOP beat; tin_count peaks at 1.
- CAPTURE_LAST=1: a packet with TUSER 0xA on beat 0 and 0xB on the tlast beat → tuple 0xB; a single-beat packet with 0xC → exactly one tuple 0xC.
- tin_ready=0, DEPTH=4, six packets sent:
  - four tuples accepted; tin_count=4.
  - tin_aready low only on the fifth packet's capture beat; the fourth packet's tail beats flow.
  - raise tin_ready → tuples drain in order; fifth capture beat accepted the cycle after the first pop.
- Full FIFO with simultaneous pop and capture-beat request → push refused that cycle, accepted next cycle; no tuple lost or duplicated; order preserved.
- Assert tin_arst_n low mid-packet with 2 tuples queued:
  - immediate tin_valid=0, tin_data=0, tin_count=0.
  - after release, the next beat (TUSER 0x77) is captured as SOP → tuple 0x77.
- Random AXIS and tin_ready stalls, 10k packets → scoreboard: tuple sequence equals per-packet capture-beat TUSER sequence; tin_data stable whenever tin_valid & ~tin_ready.
